axis_pkt_tx: RTL
================

# axis_pkt_tx

Byte-wide AXI-Stream packet transmitter: the source end of the stream interface our FIFO accepts on its input side. On a length/seed command it emits one packet of incrementing bytes, with `tlast` on the final beat. It holds each beat stable under backpressure and counts completed packets. It is used as the traffic source in front of the FIFO in loopback and bring-up builds.

## Interface
- `GAP_CYCLES`, default 4: number of idle cycles inserted after each packet. Width is 8 bits; legal range is 1..255. Only used when `PKT_GAP_EN` is defined.
- `clk` in 1: clock. Every register changes on the rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: a command is presented.
- `cmd_ready` out 1: the block can accept a command.
- `cmd_len` in 12: packet length in bytes. Legal range is 1..4095; 0 means a null command.
- `cmd_seed` in 8: value of the first data byte.
- `output_tdata` out 8: stream data.
- `output_tvalid` out 1: a stream beat is valid.
- `output_tready` in 1: the sink accepts the beat.
- `output_tlast` out 1: marks the final beat of the packet.
- `busy` out 1: high whenever the state is not IDLE.
- `pkt_count` out 16: number of completed packets, wrapping.

## Operation
- States are IDLE, LOAD, SEND and GAP. GAP exists only with `PKT_GAP_EN`.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`, the block latches `cmd_len` into `remaining` and `cmd_seed` into the data register.
  - If `cmd_len`!=0 → LOAD; if `cmd_len`==0 → stay in IDLE (null command).
- LOAD (one cycle): drive `output_tvalid`=1, `output_tdata`=seed and `output_tlast`=(`remaining`==1). → SEND.
- SEND, on a beat (`output_tvalid`&&`output_tready`):
  - Not last: `output_tdata` increments mod 256 (0xFF→0x00), `remaining` decrements, and `output_tlast`=(new `remaining`==1).
  - Last: `output_tvalid`←0, `output_tlast`←0, `pkt_count` increments (0xFFFF→0x0000).
  - After the last beat the state goes to GAP with `PKT_GAP_EN`, otherwise to IDLE.
- SEND without a beat: `output_tdata`, `output_tvalid` and `output_tlast` hold exactly. `output_tvalid` never falls without a handshake.
- GAP: counts `GAP_CYCLES` cycles, then → IDLE. `output_tvalid`=0 and `cmd_ready`=0 throughout.
- A null command:
  - emits no beats;
  - leaves `pkt_count` unchanged;
  - leaves `cmd_ready` high in the next cycle;
  - never enters GAP.
- `output_tdata` keeps the last value sent when `output_tvalid`=0. Nothing may depend on that value.
- All outputs are registered except `cmd_ready` and `busy`, which are decoded from the state.

## Timing
- Reset values:
  - state=IDLE;
  - `cmd_ready`=1, `busy`=0;
  - `output_tvalid`=0, `output_tlast`=0, `output_tdata`=0x00;
  - `pkt_count`=0, `remaining`=0, gap counter=0.
- Asserting `reset_n` mid-packet drops `output_tvalid` asynchronously. The packet is lost and is not counted.
- Command accept at edge N gives `output_tvalid`=1 after edge N+1 (one LOAD cycle).
- With `output_tready` held at 1, a packet of length L occupies L consecutive beat cycles. The last beat is at edge N+1+L.
- `pkt_count` updates at the same edge as the last handshake.
- Without the macro, `cmd_ready`=1 in the cycle after the last beat. The minimum packet-to-packet spacing is 2 idle cycles: IDLE plus LOAD.
- With the macro, `cmd_ready` rises `GAP_CYCLES` cycles after the last beat.
- A single-beat packet (L=1) has `output_tlast`=1 together with `output_tvalid`.

## Configuration
- `AXIS_PKT_TX_GAP_EN`:
  - When defined, the GAP state and an 8-bit gap counter are compiled in, and `GAP_CYCLES` idle cycles follow every non-null packet.
  - When undefined, SEND returns directly to IDLE and no gap logic exists.

## Test plan
- Reset, then command len=4 and seed=0xFE with `output_tready`=1 → beats FE, FF, 00, 01 on consecutive cycles, `output_tlast` only on 01, and `pkt_count`=1.
- Command len=3 and seed=0x10, with `output_tready` low for 5 cycles on each beat → data 10/11/12 held stable, `output_tvalid` never drops, `output_tlast` held on 12, and `pkt_count`=1.
- Command len=0 → no `output_tvalid`, `pkt_count` unchanged, and `cmd_ready`=1 in the next cycle. Then command len=1 and seed=0xAA → a single beat AA with `output_tlast`=1.
- Command len=4095 with `output_tready`=1 → 4095 beats, data wraps every 256, `output_tlast` on beat 4095, and `pkt_count`=1.
- Deassert `reset_n` during beat 2 of a len=8 packet → `output_tvalid`=0 immediately, `pkt_count`=0, and `cmd_ready`=1 after release.
- With `AXIS_PKT_TX_GAP_EN` and `GAP_CYCLES`=4, two back-to-back len=2 commands → 4 cycles of `cmd_ready`=0 after the first `output_tlast`, and `pkt_count`=2.

Source files
------------

// File: rtl/axis_pkt_tx.sv
// ---------------------------------------------------------------------------
// axis_pkt_tx
//
// Byte-wide AXI-Stream packet source. Each length/seed command produces one
// packet of incrementing bytes that starts at the seed and wraps mod 256.
// tlast marks the final beat. Beats are held stable under backpressure, and
// completed packets are counted.
//
// Optional feature macro: AXIS_PKT_TX_GAP_EN
//   When defined, a GAP state and an 8-bit gap counter are compiled in, and
//   GAP_CYCLES idle cycles follow every non-null packet. When undefined, the
//   FSM returns from SEND directly to IDLE.
//
// Parameters:
//   GAP_CYCLES    - idle cycles after each packet (1..255), gap build only
//
// Ports:
//   clk           - clock, rising edge
//   reset_n       - asynchronous active-low reset
//   cmd_valid     - command presented
//   cmd_ready     - block can accept a command (decoded from state)
//   cmd_len       - packet length in bytes, 0 = null command
//   cmd_seed      - value of the first data byte
//   output_tdata  - stream data (registered)
//   output_tvalid - stream beat valid (registered)
//   output_tready - sink accepts the beat
//   output_tlast  - final beat of the packet (registered)
//   busy          - state is not IDLE (decoded from state)
//   pkt_count     - completed packets, wrapping (registered)
// ---------------------------------------------------------------------------
module axis_pkt_tx #(
  parameter logic [7:0] GAP_CYCLES = 8'd4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [11:0] cmd_len,
  input  logic [7:0]  cmd_seed,
  output logic [7:0]  output_tdata,
  output logic        output_tvalid,
  input  logic        output_tready,
  output logic        output_tlast,
  output logic        busy,
  output logic [15:0] pkt_count
);

`ifdef AXIS_PKT_TX_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SEND = 2'd2, GAP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SEND = 2'd2} state_t;
`endif

  // A zero gap would make the gap counter compare against 0xFF.
  if (GAP_CYCLES == 8'd0) begin : g_gap_range
    $error("axis_pkt_tx: GAP_CYCLES must be in 1..255");
  end

  state_t      state_q, state_d;
  logic [11:0] remaining_q, remaining_d;
  logic [7:0]  seed_q, seed_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic [15:0] count_q, count_d;
`ifdef AXIS_PKT_TX_GAP_EN
  logic [7:0]  gap_q, gap_d;
`endif

  assign cmd_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign output_tdata  = tdata_q;
  assign output_tvalid = tvalid_q;
  assign output_tlast  = tlast_q;
  assign pkt_count     = count_q;

  // State and datapath registers. The asynchronous reset drops tvalid at
  // once, so a packet in flight is abandoned and is not counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      remaining_q <= 12'd0;
      seed_q      <= 8'h00;
      tdata_q     <= 8'h00;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      count_q     <= 16'd0;
`ifdef AXIS_PKT_TX_GAP_EN
      gap_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      seed_q      <= seed_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      count_q     <= count_d;
`ifdef AXIS_PKT_TX_GAP_EN
      gap_q       <= gap_d;
`endif
    end
  end

  // Next-state and next-output logic. Every register holds by default,
  // which also gives exact beat stability in SEND while tready is low.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    seed_d      = seed_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    count_d     = count_q;
`ifdef AXIS_PKT_TX_GAP_EN
    gap_d       = gap_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          // A null command is latched but leaves the FSM in IDLE.
          remaining_d = cmd_len;
          seed_d      = cmd_seed;
          if (cmd_len != 12'd0) begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        // The seed is only moved onto tdata here, so tdata keeps the last
        // byte actually sent while the block is idle.
        tvalid_d = 1'b1;
        tdata_d  = seed_q;
        tlast_d  = (remaining_q == 12'd1);
        state_d  = SEND;
      end
      SEND: begin
        if (tvalid_q && output_tready) begin
          if (remaining_q == 12'd1) begin
            tvalid_d    = 1'b0;
            tlast_d     = 1'b0;
            remaining_d = 12'd0;
            count_d     = count_q + 16'd1;
`ifdef AXIS_PKT_TX_GAP_EN
            gap_d       = 8'd0;
            state_d     = GAP;
`else
            state_d     = IDLE;
`endif
          end else begin
            tdata_d     = tdata_q + 8'd1;
            remaining_d = remaining_q - 12'd1;
            tlast_d     = (remaining_q == 12'd2);
          end
        end
      end
`ifdef AXIS_PKT_TX_GAP_EN
      GAP: begin
        // The counter starts at 0 on entry, so GAP lasts GAP_CYCLES cycles.
        if (gap_q == GAP_CYCLES - 8'd1) begin
          gap_d   = 8'd0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
